// File: rtl/ysyx_041514_alu_div_iter.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU and W variants.
// One quotient bit per cycle; quotient and remainder returned with a one-cycle ready pulse.
module ysyx_041514_alu_div_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_valid_i,
  input  logic        div32_valid_i,
  input  logic [63:0] sr1_data_i,
  input  logic [63:0] sr2_data_i,
  input  logic        div_valid_i,
  output logic        div_ready_o,
  output logic [63:0] div_out_o,
  output logic [63:0] rem_out_o
);

  localparam int unsigned XLEN = 64;
  localparam int unsigned HALF = 32;
  localparam int unsigned CW   = 7;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_dvs;
  logic            r_w32;
  logic            r_neg_q;
  logic            r_neg_r;

  logic [HALF-1:0] w_a32;
  logic [HALF-1:0] w_b32;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_abs;
  logic [XLEN-1:0] w_b_abs;
  logic [XLEN-1:0] w_quo_init;
  logic            w_b_zero;
  logic            w_ovf;
  logic [XLEN:0]   w_shift;
  logic            w_borrow;
  logic [XLEN-1:0] w_rem_nxt;
  logic [XLEN-1:0] w_quo_nxt;
  logic [XLEN-1:0] w_q_fin;
  logic [XLEN-1:0] w_r_fin;
  logic [HALF-1:0] w_q32;
  logic [HALF-1:0] w_r32;

  // Operand preparation: absolute values for signed, low word for W variants
  always_comb begin
    w_a32    = sr1_data_i[HALF-1:0];
    w_b32    = sr2_data_i[HALF-1:0];
    w_a_neg  = signed_valid_i & (div32_valid_i ? w_a32[HALF-1] : sr1_data_i[XLEN-1]);
    w_b_neg  = signed_valid_i & (div32_valid_i ? w_b32[HALF-1] : sr2_data_i[XLEN-1]);
    w_b_zero = div32_valid_i ? (w_b32 == '0) : (sr2_data_i == '0);
    if (div32_valid_i) begin
      w_a_abs = {{HALF{1'b0}}, (w_a_neg ? (HALF'(0) - w_a32) : w_a32)};
      w_b_abs = {{HALF{1'b0}}, (w_b_neg ? (HALF'(0) - w_b32) : w_b32)};
      w_ovf   = signed_valid_i & (w_a32 == {1'b1, {(HALF-1){1'b0}}}) & (w_b32 == '1);
      w_quo_init = {w_a_abs[HALF-1:0], {HALF{1'b0}}};
    end else begin
      w_a_abs = w_a_neg ? (XLEN'(0) - sr1_data_i) : sr1_data_i;
      w_b_abs = w_b_neg ? (XLEN'(0) - sr2_data_i) : sr2_data_i;
      w_ovf   = signed_valid_i & (sr1_data_i == {1'b1, {(XLEN-1){1'b0}}}) & (sr2_data_i == '1);
      w_quo_init = w_a_abs;
    end
  end

  // One restoring step plus the sign fix-up applied to its result
  always_comb begin
    w_shift   = {r_rem, r_quo[XLEN-1]};
    w_borrow  = (w_shift < {1'b0, r_dvs});
    w_rem_nxt = w_borrow ? w_shift[XLEN-1:0] : (w_shift[XLEN-1:0] - r_dvs);
    w_quo_nxt = {r_quo[XLEN-2:0], ~w_borrow};
    w_q32     = r_neg_q ? (HALF'(0) - w_quo_nxt[HALF-1:0]) : w_quo_nxt[HALF-1:0];
    w_r32     = r_neg_r ? (HALF'(0) - w_rem_nxt[HALF-1:0]) : w_rem_nxt[HALF-1:0];
    if (r_w32) begin
      w_q_fin = {{HALF{1'b0}}, w_q32};
      w_r_fin = {{HALF{1'b0}}, w_r32};
    end else begin
      w_q_fin = r_neg_q ? (XLEN'(0) - w_quo_nxt) : w_quo_nxt;
      w_r_fin = r_neg_r ? (XLEN'(0) - w_rem_nxt) : w_rem_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_dvs       <= '0;
      r_w32       <= 1'b0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      div_ready_o <= 1'b0;
      div_out_o   <= '0;
      rem_out_o   <= '0;
    end else begin
      div_ready_o <= 1'b0;
      case (r_state)
        IDLE: begin
          if (div_valid_i) begin
            r_w32   <= div32_valid_i;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_quo   <= w_quo_init;
            r_rem   <= '0;
            r_dvs   <= w_b_abs;
            if (w_b_zero) begin
              r_state     <= DONE;
              div_ready_o <= 1'b1;
              div_out_o   <= div32_valid_i ? {{HALF{1'b0}}, {HALF{1'b1}}} : '1;
              rem_out_o   <= div32_valid_i ? {{HALF{1'b0}}, w_a32} : sr1_data_i;
            end else if (w_ovf) begin
              r_state     <= DONE;
              div_ready_o <= 1'b1;
              div_out_o   <= div32_valid_i ? {{HALF{1'b0}}, w_a32} : sr1_data_i;
              rem_out_o   <= '0;
            end else begin
              r_state <= CALC;
              r_cnt   <= div32_valid_i ? CW'(HALF) : CW'(XLEN);
            end
          end
        end
        CALC: begin
          if (!div_valid_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
              r_state     <= DONE;
              div_ready_o <= 1'b1;
              div_out_o   <= w_q_fin;
              rem_out_o   <= w_r_fin;
            end
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
